// File: rtl/apb4_master_bridge_if.sv
// apb4_master_bridge_if: bundles the command/response handshake and the
// APB4 bus signals of the APB4 requester bridge.
//   master modport: the bridge (drives the APB request and the response).
//   slave  modport: the environment (issues commands, plays the completer).
interface apb4_master_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Command side
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [DATA_WIDTH-1:0]     cmd_wdata;
    logic [DATA_WIDTH/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;
    // Response side
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      rsp_err;
    // APB4 bus
    logic                      PSEL;
    logic                      PENABLE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic                      PWRITE;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic                      PREADY;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: APB4 requester. Turns valid/ready commands into
// SETUP/ACCESS transfers and reports completion on a one-cycle rsp_valid.
// Optional feature: define APB4_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES wait states (reported as rsp_err=1, rsp_rdata=0).
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    apb4_master_bridge_if.master  bus
);
    localparam int STRB_W = DATA_WIDTH / 8;

    // Elaboration-time rejection of unsupported configurations.
    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb4_master_bridge: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   cmd_ready_s;
    logic                   psel_s;
    logic                   penable_s;
    logic                   accept_s;
    logic                   complete_s;
    logic                   timeout_s;

    logic [ADDR_WIDTH-1:0]  paddr_r;
    logic                   pwrite_r;
    logic [DATA_WIDTH-1:0]  pwdata_r;
    logic [STRB_W-1:0]      pstrb_r;
    logic [2:0]             pprot_r;
    logic                   rsp_valid_r;
    logic [DATA_WIDTH-1:0]  rsp_rdata_r;
    logic                   rsp_err_r;

    assign accept_s   = bus.cmd_valid && cmd_ready_s;
    assign complete_s = (state_r == ACCESS) && bus.PREADY;

`ifdef APB4_MASTER_TIMEOUT_EN
    // Counter only has to reach TIMEOUT_CYCLES-1; the abort fires on the
    // edge that would make it TIMEOUT_CYCLES.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WAIT_W-1:0] wait_cnt_r;

    // Wait-state counter: cleared outside ACCESS, counts stalled ACCESS cycles.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ACCESS) && !bus.PREADY) begin
            wait_cnt_r <= wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end
    end

    // PREADY on the same edge wins because it is excluded here.
    assign timeout_s = (state_r == ACCESS) && !bus.PREADY &&
                       (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: SETUP is always one cycle; ACCESS exits on PREADY or timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                if (complete_s) begin
                    state_nxt_s = accept_s ? SETUP : IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: PSEL/PENABLE follow the state register, cmd_ready is forced low in reset.
    always_comb begin
        psel_s      = 1'b0;
        penable_s   = 1'b0;
        cmd_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                psel_s      = 1'b0;
                penable_s   = 1'b0;
                cmd_ready_s = 1'b1;
            end
            SETUP: begin
                psel_s      = 1'b1;
                penable_s   = 1'b0;
                cmd_ready_s = 1'b0;
            end
            ACCESS: begin
                psel_s      = 1'b1;
                penable_s   = 1'b1;
                cmd_ready_s = bus.PREADY;
            end
            default: begin
                psel_s      = 1'b0;
                penable_s   = 1'b0;
                cmd_ready_s = 1'b0;
            end
        endcase
        if (PRESET) begin
            cmd_ready_s = 1'b0;
        end else begin
            cmd_ready_s = cmd_ready_s;
        end
    end

    // Request capture: APB address/control loaded on accept and held for the whole transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_r  <= {ADDR_WIDTH{1'b0}};
            pwrite_r <= 1'b0;
            pwdata_r <= {DATA_WIDTH{1'b0}};
            pstrb_r  <= {STRB_W{1'b0}};
            pprot_r  <= 3'b000;
        end else if (accept_s) begin
            paddr_r  <= bus.cmd_addr;
            pwrite_r <= bus.cmd_write;
            pprot_r  <= bus.cmd_prot;
            // Reads carry no strobes; PWDATA keeps the last written value.
            pwdata_r <= bus.cmd_write ? bus.cmd_wdata : pwdata_r;
            pstrb_r  <= bus.cmd_write ? bus.cmd_strb : {STRB_W{1'b0}};
        end else begin
            paddr_r  <= paddr_r;
            pwrite_r <= pwrite_r;
            pwdata_r <= pwdata_r;
            pstrb_r  <= pstrb_r;
            pprot_r  <= pprot_r;
        end
    end

    // Response register: one-cycle strobe after completion or timeout abort.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (complete_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : bus.PRDATA;
            rsp_err_r   <= bus.PSLVERR;
        end else if (timeout_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b1;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.PSEL      = psel_s;
    assign bus.PENABLE   = penable_s;
    assign bus.PADDR     = paddr_r;
    assign bus.PWRITE    = pwrite_r;
    assign bus.PWDATA    = pwdata_r;
    assign bus.PSTRB     = pstrb_r;
    assign bus.PPROT     = pprot_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;
endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: scoreboard bench for apb4_master_bridge.
// Expected responses are queued when a command is accepted and compared
// when rsp_valid appears. A behavioural completer inserts wait states.
module tb_apb4_master_bridge;
    logic PCLK   = 1'b0;
    logic PRESET = 1'b1;

    always #5 PCLK = ~PCLK;

    apb4_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb4_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [32:0] exp_q[$];
    int          rsp_cycles[$];
    int          cycle        = 0;

    // Completer behaviour for the transfer in flight.
    int          waits_cfg      = 0;
    logic [31:0] rdata_cfg      = 32'h0;
    logic        err_cfg        = 1'b0;
    logic        expect_timeout = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge PCLK) cycle <= cycle + 1;

    // Scoreboard push: model the response for every accepted command.
    always @(posedge PCLK) begin
        if (!PRESET && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
            if (expect_timeout)
                exp_q.push_back({1'b1, 32'h0});
            else if (bus.cmd_write)
                exp_q.push_back({err_cfg, 32'h0});
            else
                exp_q.push_back({err_cfg, rdata_cfg});
        end
    end

    // Scoreboard pop: compare each response strobe.
    initial begin : rsp_mon
        logic [32:0] e;
        forever begin
            @(negedge PCLK);
            if (bus.rsp_valid === 1'b1) begin
                rsp_cycles.push_back(cycle);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e[32]});
                    check("rsp_rdata", {32'd0, bus.rsp_rdata}, {32'd0, e[31:0]});
                end
            end
        end
    end

    // Completer: PREADY after waits_cfg stalled ACCESS cycles; junk data otherwise.
    initial begin : completer
        int acc;
        acc         = 0;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hBAD0_BAD0;
        bus.PSLVERR = 1'b1;
        forever begin
            @(posedge PCLK);
            #2;
            if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
                if (acc >= waits_cfg) begin
                    bus.PREADY  = 1'b1;
                    bus.PRDATA  = rdata_cfg;
                    bus.PSLVERR = err_cfg;
                end else begin
                    bus.PREADY  = 1'b0;
                    bus.PRDATA  = 32'hBAD0_BAD0;
                    bus.PSLVERR = 1'b1;
                end
                acc++;
            end else begin
                acc         = 0;
                bus.PREADY  = 1'b0;
                bus.PRDATA  = 32'hBAD0_BAD0;
                bus.PSLVERR = 1'b1;
            end
        end
    end

    // Present a command and return at the negedge after it was accepted.
    task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        int n;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
        bus.cmd_prot  = p;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge PCLK);
            n++;
        end
        if (n >= 50) check("accept_bound", 64'd0, 64'd1);
        @(negedge PCLK);
    endtask

    // Wait (bounded) until every queued response was seen, then realign to a negedge.
    task automatic drain(input string tag);
        int n;
        n = 0;
        #1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        @(negedge PCLK);
    endtask

    initial begin : main
        int cnt;
        int base;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_strb  = 4'h0;
        bus.cmd_prot  = 3'b000;

        // Reset state: every output low, cmd_ready low despite cmd_valid.
        repeat (2) @(negedge PCLK);
        bus.cmd_valid = 1'b1;
        #1;
        check("rst_psel", {63'd0, bus.PSEL}, 64'd0);
        check("rst_penable", {63'd0, bus.PENABLE}, 64'd0);
        check("rst_paddr", {32'd0, bus.PADDR}, 64'd0);
        check("rst_pwrite", {63'd0, bus.PWRITE}, 64'd0);
        check("rst_pwdata", {32'd0, bus.PWDATA}, 64'd0);
        check("rst_pstrb", {60'd0, bus.PSTRB}, 64'd0);
        check("rst_pprot", {61'd0, bus.PPROT}, 64'd0);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_rdata", {32'd0, bus.rsp_rdata}, 64'd0);
        check("rst_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        check("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("idle_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);

        // Single write, no wait states.
        waits_cfg = 0; err_cfg = 1'b0; rdata_cfg = 32'h1111_2222;
        send(1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 3'b010);
        bus.cmd_valid = 1'b0;
        check("wr_setup_psel", {63'd0, bus.PSEL}, 64'd1);
        check("wr_setup_penable", {63'd0, bus.PENABLE}, 64'd0);
        check("wr_paddr", {32'd0, bus.PADDR}, 64'h10);
        check("wr_pwrite", {63'd0, bus.PWRITE}, 64'd1);
        check("wr_pwdata", {32'd0, bus.PWDATA}, 64'hA5A5_0001);
        check("wr_pstrb", {60'd0, bus.PSTRB}, 64'hF);
        check("wr_pprot", {61'd0, bus.PPROT}, 64'd2);
        check("wr_setup_ready", {63'd0, bus.cmd_ready}, 64'd0);
        @(negedge PCLK);
        check("wr_access_psel", {63'd0, bus.PSEL}, 64'd1);
        check("wr_access_penable", {63'd0, bus.PENABLE}, 64'd1);
        @(negedge PCLK);
        check("wr_done_psel", {63'd0, bus.PSEL}, 64'd0);
        check("wr_done_penable", {63'd0, bus.PENABLE}, 64'd0);
        check("wr_rsp_pulse", {63'd0, bus.rsp_valid}, 64'd1);
        @(negedge PCLK);
        check("wr_rsp_one_cycle", {63'd0, bus.rsp_valid}, 64'd0);
        drain("wr_drain");

        // Read with three wait states.
        waits_cfg = 3; rdata_cfg = 32'hDEAD_BEEF;
        send(1'b0, 32'h14, 32'h5555_5555, 4'hF, 3'b000);
        bus.cmd_valid = 1'b0;
        check("rd_pstrb", {60'd0, bus.PSTRB}, 64'd0);
        check("rd_pwrite", {63'd0, bus.PWRITE}, 64'd0);
        check("rd_pwdata_held", {32'd0, bus.PWDATA}, 64'hA5A5_0001);
        check("rd_paddr", {32'd0, bus.PADDR}, 64'h14);
        @(negedge PCLK);
        cnt = 0;
        while (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge PCLK);
        end
        check("rd_access_cycles", 64'(cnt), 64'd4);
        check("rd_done_psel", {63'd0, bus.PSEL}, 64'd0);
        drain("rd_drain");

        // Back-to-back write then read with cmd_valid held.
        waits_cfg = 0; rdata_cfg = 32'h1234_5678;
        base = rsp_cycles.size();
        bus.cmd_write = 1'b1; bus.cmd_addr = 32'h20; bus.cmd_wdata = 32'h0BAB_E000;
        bus.cmd_strb = 4'h3; bus.cmd_prot = 3'b001; bus.cmd_valid = 1'b1;
        @(negedge PCLK);
        check("b2b_p0", {62'd0, bus.PSEL, bus.PENABLE}, 64'b10);
        bus.cmd_write = 1'b0; bus.cmd_addr = 32'h24;
        @(negedge PCLK);
        check("b2b_p1", {62'd0, bus.PSEL, bus.PENABLE}, 64'b11);
        @(negedge PCLK);
        check("b2b_p2", {62'd0, bus.PSEL, bus.PENABLE}, 64'b10);
        check("b2b_paddr2", {32'd0, bus.PADDR}, 64'h24);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        check("b2b_p3", {62'd0, bus.PSEL, bus.PENABLE}, 64'b11);
        drain("b2b_drain");
        check("b2b_rsp_count", 64'(rsp_cycles.size() - base), 64'd2);
        if (rsp_cycles.size() - base == 2)
            check("b2b_rsp_gap", 64'(rsp_cycles[base+1] - rsp_cycles[base]), 64'd2);

        // Slave error on a write, then a clean read.
        waits_cfg = 1; err_cfg = 1'b1;
        send(1'b1, 32'h40, 32'h0000_00FF, 4'h1, 3'b000);
        bus.cmd_valid = 1'b0;
        drain("err_wr_drain");
        err_cfg = 1'b0; rdata_cfg = 32'hCAFE_0042;
        send(1'b0, 32'h44, 32'h0, 4'h0, 3'b000);
        bus.cmd_valid = 1'b0;
        drain("err_rd_drain");

        // Reset during an ACCESS wait state aborts silently.
        waits_cfg = 10;
        send(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        check("abort_in_access", {63'd0, bus.PENABLE}, 64'd1);
        #2;
        PRESET = 1'b1;
        #1;
        check("abort_psel", {63'd0, bus.PSEL}, 64'd0);
        check("abort_penable", {63'd0, bus.PENABLE}, 64'd0);
        check("abort_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        exp_q.delete();
        base = rsp_cycles.size();
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        check("abort_no_rsp", 64'(rsp_cycles.size() - base), 64'd0);
        waits_cfg = 0;
        send(1'b1, 32'h60, 32'h6060_6060, 4'hF, 3'b000);
        bus.cmd_valid = 1'b0;
        drain("post_rst_drain");
        check("post_rst_rsp", 64'(rsp_cycles.size() - base), 64'd1);

`ifdef APB4_MASTER_TIMEOUT_EN
        // Completer never ready: abort after TIMEOUT_CYCLES stalled ACCESS cycles.
        waits_cfg = 1000; expect_timeout = 1'b1;
        send(1'b0, 32'h70, 32'h0, 4'h0, 3'b000);
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        cnt = 0;
        while (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge PCLK);
        end
        check("to_access_cycles", 64'(cnt), 64'd4);
        check("to_psel", {63'd0, bus.PSEL}, 64'd0);
        check("to_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        check("to_idle_ready", {63'd0, bus.cmd_ready}, 64'd1);
        drain("to_drain");
        expect_timeout = 1'b0;
        waits_cfg = 0;
`endif

        repeat (3) @(negedge PCLK);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- APB4 requester (initiator) RTL: converts a simple valid/ready command interface into APB4 SETUP/ACCESS transfers and returns read data/error on a single-cycle response strobe.
- The DUT-side counterpart of our APB4 slave VIP.
- Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT toward one APB4 completer; samples PREADY/PRDATA/PSLVERR.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA; must be 8, 16 or 32
- TIMEOUT_CYCLES, 16, max ACCESS-phase wait-state cycles (used only with the optional feature)

Ports:
- PCLK  in  1  APB clock; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at PCLK edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  transfer address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- cmd_prot  in  3  PPROT value
- rsp_valid  out  1  one-cycle pulse, transfer complete
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_err  out  1  PSLVERR sampled at completion (or timeout)
- PSEL  out  1
- PENABLE  out  1
- PADDR  out  ADDR_WIDTH
- PWRITE  out  1
- PWDATA  out  DATA_WIDTH
- PSTRB  out  DATA_WIDTH/8
- PPROT  out  3
- PREADY  in  1
- PRDATA  in  DATA_WIDTH
- PSLVERR  in  1

Behaviour:
- Reset (PRESET=1, async): state IDLE; all outputs 0 (PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, cmd_ready combinational but 0 while PRESET=1).
- FSM states: IDLE, SETUP, ACCESS.
- cmd_ready = (state==IDLE) || (state==ACCESS && PREADY); no command accepted in SETUP.
- IDLE: on accept -> SETUP; register addr/write/wdata/strb/prot onto APB outputs; PSEL=1, PENABLE=0.
- SETUP: exactly one cycle -> ACCESS; PENABLE=1; APB outputs held stable.
- ACCESS, PREADY=0: stay, all APB outputs stable (wait states unbounded unless feature enabled).
- ACCESS, PREADY=1: transfer completes that edge; next cycle rsp_valid=1, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads, 0 for writes. Next state SETUP if a new command is accepted on the same edge (back-to-back, PSEL stays 1, PENABLE drops to 0), else IDLE (PSEL=0, PENABLE=0).
- Minimum 2 PCLK cycles per transfer; back-to-back throughput 1 transfer per 2 cycles.
- Reads: PSTRB driven 0 regardless of cmd_strb (APB4 rule). PWDATA holds last write value during reads.
- PSLVERR/PRDATA ignored except at the completing ACCESS edge.
- rsp_valid has no backpressure; consumer must take it in that cycle.
- PRESET asserted mid-transfer: PSEL/PENABLE drop immediately, no rsp_valid for the aborted transfer.

Optional Feature:
- Macro APB4_MASTER_TIMEOUT_EN.
- Defined: wait counter cleared on entering ACCESS, increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the transfer is aborted: next cycle PSEL=0, PENABLE=0, state IDLE, and rsp_valid=1 with rsp_err=1 and rsp_rdata=0. Completing with PREADY on the same edge takes priority over the timeout.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write addr 0x10, data 0xA5A5_0001, strb 0xF, PREADY tied 1 -> PSEL=1/PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle; rsp_valid pulse with rsp_err=0, rsp_rdata=0.
- Read addr 0x14, completer returns 0xDEAD_BEEF after 3 wait states -> ACCESS lasts 4 cycles, PSTRB=0, rsp_rdata=0xDEAD_BEEF.
- Back-to-back write 0x20 then read 0x24 with cmd_valid held -> PSEL stays 1, PENABLE pattern 0,1,0,1; two rsp_valid pulses 2 cycles apart.
- Write with PSLVERR=1 at completion -> rsp_err=1; following read with PSLVERR=0 -> rsp_err=0.
- PRESET asserted during ACCESS wait state -> PSEL/PENABLE 0 within the same cycle, no rsp_valid; after release, new command completes normally.
- With APB4_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 wait cycles, rsp_valid with rsp_err=1, rsp_rdata=0, FSM back to IDLE.
